// File: rtl/memory_test_sequencer.sv
// Multi-pass sequencer for the AXI memory checker.
// Holds the checker in reset, releases it, starts it, waits for done under a
// watchdog, records the result and re-arms it for the next pass. The checker's
// DONE is terminal, so every pass begins with a fresh reset pulse.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | no run active, checker held in reset, waiting for run edge
// S_RESET_CHK  | checker held in reset for SETTLE_CYCLES before a pass
// S_ARM        | checker out of reset for one cycle, start goes high next
// S_WAIT_DONE  | start high, waiting for checker done under the watchdog
// S_RECORD     | one cycle to log the pass result and decide what follows
// S_DONE       | run finished, results held until run drops
module memory_test_sequencer #(
    parameter int NUM_PASSES     = 4,
    parameter int TIMEOUT_CYCLES = 2**24,
    parameter int SETTLE_CYCLES  = 16,
    parameter bit STOP_ON_FAIL   = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             axi_clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             abort_i,
    output logic             chk_rstn_o,
    output logic             chk_start_o,
    input  logic             chk_done_i,
    input  logic             chk_pass_i,
    output logic             busy_o,
    output logic             seq_done_o,
    output logic             seq_pass_o,
    output logic             timeout_flag_o,
    output logic [CNT_W-1:0] cur_pass_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   IDX_ONE     = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   PASSES_C    = (CNT_W+1)'(NUM_PASSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_CHK,
        S_ARM,
        S_WAIT_DONE,
        S_RECORD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               run_q;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               chk_rstn_q, chk_rstn_d;
    logic               chk_start_q, chk_start_d;
    logic               seq_done_q, seq_done_d;
    logic               seq_pass_q, seq_pass_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]   cur_pass_q, cur_pass_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic               run_edge;
    logic               busy;
    logic               enter_done;
    logic               last_pass;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign run_edge  = run_i & ~run_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign last_pass = (NUM_PASSES != 0) && (({1'b0, cur_pass_q} + IDX_ONE) == PASSES_C);

    // Next-state, counter and flag logic; abort overrides the normal transitions.
    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        chk_start_d    = chk_start_q;
        seq_done_d     = seq_done_q;
        seq_pass_d     = seq_pass_q;
        timeout_flag_d = timeout_flag_q;
        cur_pass_d     = cur_pass_q;
        pass_cnt_d     = pass_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        enter_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_edge) begin
                    state_d        = S_RESET_CHK;
                    settle_cnt_d   = '0;
                    cur_pass_d     = '0;
                    pass_cnt_d     = '0;
                    fail_cnt_d     = '0;
                    seq_done_d     = 1'b0;
                    seq_pass_d     = 1'b0;
                    timeout_flag_d = 1'b0;
                end
            end
            S_RESET_CHK: begin
                settle_cnt_d = settle_cnt_q + SETTLE_ONE;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                chk_start_d = 1'b1;
                tmo_cnt_d   = '0;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                // done on the terminal cycle still counts as a completed pass
                if (chk_done_i) begin
                    state_d = S_RECORD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_flag_d = 1'b1;
                    fail_cnt_d     = sat_inc(fail_cnt_q);
                    cur_pass_d     = sat_inc(cur_pass_q);
                    chk_start_d    = 1'b0;
                    enter_done     = 1'b1;
                end
            end
            S_RECORD: begin
                chk_start_d = 1'b0;
                cur_pass_d  = sat_inc(cur_pass_q);
                if (chk_pass_i) begin
                    pass_cnt_d = sat_inc(pass_cnt_q);
                end else begin
                    fail_cnt_d = sat_inc(fail_cnt_q);
                end
                if (last_pass) begin
                    enter_done = 1'b1;
                end else if (STOP_ON_FAIL && !chk_pass_i) begin
                    enter_done = 1'b1;
                end else begin
                    state_d      = S_RESET_CHK;
                    settle_cnt_d = '0;
                end
            end
            S_DONE: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // seq_pass is judged on the counters as they will be after this edge
        if (enter_done) begin
            state_d    = S_DONE;
            seq_done_d = 1'b1;
            seq_pass_d = (fail_cnt_d == '0) && !timeout_flag_d;
        end

        // abort freezes results, dropping any update RECORD was about to make
        if (abort_i && busy) begin
            state_d        = S_DONE;
            chk_start_d    = 1'b0;
            seq_done_d     = 1'b1;
            seq_pass_d     = 1'b0;
            timeout_flag_d = timeout_flag_q;
            cur_pass_d     = cur_pass_q;
            pass_cnt_d     = pass_cnt_q;
            fail_cnt_d     = fail_cnt_q;
        end

        chk_rstn_d = (state_d == S_ARM) || (state_d == S_WAIT_DONE) || (state_d == S_RECORD);
    end

    // run_q follows run even during reset so a run held high through reset is not an edge.
    always_ff @(posedge axi_clk_i) begin
        run_q <= run_i;
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge axi_clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            settle_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            chk_rstn_q     <= 1'b0;
            chk_start_q    <= 1'b0;
            seq_done_q     <= 1'b0;
            seq_pass_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
            cur_pass_q     <= '0;
            pass_cnt_q     <= '0;
            fail_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            chk_rstn_q     <= chk_rstn_d;
            chk_start_q    <= chk_start_d;
            seq_done_q     <= seq_done_d;
            seq_pass_q     <= seq_pass_d;
            timeout_flag_q <= timeout_flag_d;
            cur_pass_q     <= cur_pass_d;
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
        end
    end

    assign chk_rstn_o     = chk_rstn_q;
    assign chk_start_o    = chk_start_q;
    assign busy_o         = busy;
    assign seq_done_o     = seq_done_q;
    assign seq_pass_o     = seq_pass_q;
    assign timeout_flag_o = timeout_flag_q;
    assign cur_pass_o     = cur_pass_q;
    assign pass_cnt_o     = pass_cnt_q;
    assign fail_cnt_o     = fail_cnt_q;

endmodule
